// File: rtl/paper_fetch_exec.sv
// paper_fetch_exec: fetch/execute controller running INC/JNO/HLT from a 2-bit instruction ROM
module paper_fetch_exec #(
  parameter int AW = 2,
  parameter int ACC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [AW-1:0]    rom_addr,
  input  logic [1:0]       rom_data,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             halted,
  output logic             illegal,
  output logic             retire
);
  typedef enum logic [1:0] {FETCH, EXEC, OPND, HALT} state_t;
  state_t state;
  logic [AW-1:0] pc;
  logic [1:0] ir;
  assign rom_addr = pc;
  assign halted = state == HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
      acc <= '0;
      ovf <= 1'b0;
      illegal <= 1'b0;
      retire <= 1'b0;
      state <= FETCH;
    end else if (run) begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          ir <= rom_data;
          pc <= pc + AW'(1);
          state <= EXEC;
        end
        EXEC: begin
          retire <= ir != 2'b01;
          state <= ir == 2'b00 ? FETCH : ir == 2'b01 ? OPND : HALT;
          if (ir == 2'b00) {ovf, acc} <= {1'b0, acc} + (ACC_W+1)'(1);
          if (ir == 2'b11) illegal <= 1'b1;
        end
        OPND: begin
          pc <= ovf ? pc + AW'(1) : AW'(rom_data);
          retire <= 1'b1;
          state <= FETCH;
        end
        default: ;
      endcase
    end else retire <= 1'b0;
  end
endmodule

// File: tb/tb_paper_fetch_exec.sv
// tb_paper_fetch_exec: instruction-level reference model checks of paper_fetch_exec at ACC_W=2 and ACC_W=3
module tb_paper_fetch_exec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [1:0] rom [4];
  logic [1:0] addr2, addr3, data2, data3, acc2;
  logic [2:0] acc3;
  logic ovf2, ovf3, halted2, halted3, ill2, ill3, ret2, ret3;
  int passed = 0;
  int total = 0;
  int edges = 0;
  int m_pc [2];
  int m_acc [2];
  int m_prog [2];
  int accw [2] = '{2, 3};
  bit m_ovf [2];
  bit m_halt [2];
  bit m_ill [2];
  bit m_ret [2];
  logic [8:0] got [2];
  logic [8:0] want [2];
  assign data2 = rom[addr2];
  assign data3 = rom[addr3];
  paper_fetch_exec #(.AW(2), .ACC_W(2)) dut2 (
    .clk(clk), .rst(rst), .run(run), .rom_addr(addr2), .rom_data(data2),
    .acc(acc2), .ovf(ovf2), .halted(halted2), .illegal(ill2), .retire(ret2)
  );
  paper_fetch_exec #(.AW(2), .ACC_W(3)) dut3 (
    .clk(clk), .rst(rst), .run(run), .rom_addr(addr3), .rom_data(data3),
    .acc(acc3), .ovf(ovf3), .halted(halted3), .illegal(ill3), .retire(ret3)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic go);
    rst = r;
    run = go;
    @(posedge clk);
    edges++;
    for (int k = 0; k < 2; k++) begin
      int op, lat;
      m_ret[k] = 1'b0;
      if (r) begin
        m_pc[k] = 0;
        m_acc[k] = 0;
        m_prog[k] = 0;
        m_ovf[k] = 1'b0;
        m_halt[k] = 1'b0;
        m_ill[k] = 1'b0;
      end else if (go && !m_halt[k]) begin
        op = int'(rom[m_pc[k]]);
        lat = op == 1 ? 3 : 2;
        m_prog[k]++;
        if (m_prog[k] == lat) begin
          m_prog[k] = 0;
          m_ret[k] = 1'b1;
          case (op)
            0: begin
              m_ovf[k] = m_acc[k] == (1 << accw[k]) - 1;
              m_acc[k] = (m_acc[k] + 1) % (1 << accw[k]);
              m_pc[k] = (m_pc[k] + 1) % 4;
            end
            1: m_pc[k] = m_ovf[k] ? (m_pc[k] + 2) % 4 : int'(rom[(m_pc[k] + 1) % 4]);
            default: begin
              m_halt[k] = 1'b1;
              m_ill[k] = op == 3;
              m_pc[k] = (m_pc[k] + 1) % 4;
            end
          endcase
        end
      end
    end
    #1;
    got[0] = {addr2 & ((m_prog[0] == 0) ? 2'b11 : 2'b00), ret2, halted2, ill2, ovf2, 1'b0, acc2};
    got[1] = {addr3 & ((m_prog[1] == 0) ? 2'b11 : 2'b00), ret3, halted3, ill3, ovf3, acc3};
    for (int k = 0; k < 2; k++)
      want[k] = {2'(m_pc[k]) & ((m_prog[k] == 0) ? 2'b11 : 2'b00), m_ret[k], m_halt[k], m_ill[k], m_ovf[k], 3'(m_acc[k])};
  endtask
  task automatic test_reset;
    step(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got[k] !== 9'd0) $display("FAIL reset dut%0d got=%b want=%b", k, got[k], 9'd0);
      else passed++;
    end
  endtask
  task automatic test_loop;
    int h2 = -1, h3 = -1, r2 = 0, r3 = 0;
    rom = '{2'b00, 2'b01, 2'b00, 2'b10};
    step(1'b1, 1'b1);
    edges = 0;
    repeat (45) begin
      step(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== want[k]) $display("FAIL loop dut%0d edge %0d got=%b want=%b", k, edges, got[k], want[k]);
        else passed++;
      end
      if (ret2) r2++;
      if (ret3) r3++;
      if (halted2 && h2 < 0) h2 = edges;
      if (halted3 && h3 < 0) h3 = edges;
    end
    total += 5;
    if (h2 !== 22) $display("FAIL loop_halt_edge_w2 got=%0d want=22", h2); else passed++;
    if (h3 !== 42) $display("FAIL loop_halt_edge_w3 got=%0d want=42", h3); else passed++;
    if (r2 !== 9) $display("FAIL loop_retires_w2 got=%0d want=9", r2); else passed++;
    if (r3 !== 17) $display("FAIL loop_retires_w3 got=%0d want=17", r3); else passed++;
    if ({acc2, ovf2, acc3, ovf3, ill2} !== 9'b00_1_000_1_0)
      $display("FAIL loop_final got=%b want=%b", {acc2, ovf2, acc3, ovf3, ill2}, 9'b00_1_000_1_0);
    else passed++;
  endtask
  task automatic test_illegal;
    int h2 = -1;
    rom = '{2'b11, 2'b00, 2'b00, 2'b00};
    step(1'b1, 1'b1);
    edges = 0;
    repeat (8) begin
      step(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== want[k]) $display("FAIL illegal dut%0d edge %0d got=%b want=%b", k, edges, got[k], want[k]);
        else passed++;
      end
      if (halted2 && h2 < 0) h2 = edges;
    end
    total += 2;
    if (h2 !== 2) $display("FAIL illegal_halt_edge got=%0d want=2", h2); else passed++;
    if ({ill2, acc2, ill3, acc3} !== 7'b1_00_1_000)
      $display("FAIL illegal_final got=%b want=%b", {ill2, acc2, ill3, acc3}, 7'b1_00_1_000);
    else passed++;
  endtask
  task automatic test_run_gaps;
    int h2 = -1;
    logic go;
    rom = '{2'b00, 2'b01, 2'b00, 2'b10};
    step(1'b1, 1'b1);
    edges = 0;
    for (int e = 1; e <= 30; e++) begin
      go = !(e >= 3 && e <= 6);
      step(1'b0, go);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== want[k]) $display("FAIL run_gaps dut%0d edge %0d got=%b want=%b", k, edges, got[k], want[k]);
        else passed++;
      end
      if (!go) begin
        total++;
        if ({ret2, ret3} !== 2'b00) $display("FAIL run_gaps_retire edge %0d got=%b want=00", e, {ret2, ret3});
        else passed++;
      end
      if (halted2 && h2 < 0) h2 = edges;
    end
    total++;
    if (h2 !== 26) $display("FAIL run_gaps_halt_edge got=%0d want=26", h2); else passed++;
  endtask
  task automatic test_reset_mid_jno;
    int h2 = -1;
    rom = '{2'b00, 2'b01, 2'b00, 2'b10};
    step(1'b1, 1'b1);
    repeat (9) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    total++;
    if ({addr2, acc2, ovf2, halted2, ret2} !== 7'd0)
      $display("FAIL reset_mid_jno got=%b want=%b", {addr2, acc2, ovf2, halted2, ret2}, 7'd0);
    else passed++;
    edges = 0;
    repeat (25) begin
      step(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== want[k]) $display("FAIL reset_mid_jno dut%0d edge %0d got=%b want=%b", k, edges, got[k], want[k]);
        else passed++;
      end
      if (halted2 && h2 < 0) h2 = edges;
    end
    total++;
    if (h2 !== 22) $display("FAIL reset_mid_jno_rerun got=%0d want=22", h2); else passed++;
  endtask
  task automatic test_jno_last_addr;
    rom = '{2'b00, 2'b00, 2'b00, 2'b01};
    step(1'b1, 1'b1);
    edges = 0;
    repeat (40) begin
      step(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== want[k]) $display("FAIL jno_last dut%0d edge %0d got=%b want=%b", k, edges, got[k], want[k]);
        else passed++;
      end
      if (edges == 9) begin
        total++;
        if ({addr2, ret2, acc2} !== 5'b00_1_11) $display("FAIL jno_last_wrap got=%b want=%b", {addr2, ret2, acc2}, 5'b00_1_11);
        else passed++;
      end
    end
  endtask
  task automatic test_random;
    for (int round = 0; round < 5; round++) begin
      for (int i = 0; i < 4; i++) rom[i] = 2'($urandom_range(0, 3));
      step(1'b1, 1'b1);
      repeat (150) begin
        step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
        for (int k = 0; k < 2; k++) begin
          total++;
          if (got[k] !== want[k]) $display("FAIL random dut%0d round %0d got=%b want=%b", k, round, got[k], want[k]);
          else passed++;
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_loop;
    test_illegal;
    test_run_gaps;
    test_reset_mid_jno;
    test_jno_last_addr;
    test_random;
    test_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
